// File: rtl/boot_seq_pkg.sv
// Shared state encoding and default memory map for the boot sequencer.
package boot_seq_pkg;

  typedef enum logic [3:0] {
    IDLE,
    LOAD,
    REQ,
    RSP,
    CHK_REQ,
    CHK_RSP,
    EN_FETCH,
    EN_IFETCH,
    RUN,
    ERROR
  } boot_state_e;

  localparam logic [31:0] DefaultBaseAddr  = 32'h0000_0080;
  localparam int unsigned DefaultMaxWords  = 32;
  localparam logic [31:0] DefaultEndMarker = 32'h0000_0FFF;

  // Byte address of a word slot; wraps modulo 2^32.
  function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [31:0] idx);
    return base + (idx << 2);
  endfunction

endpackage

// File: rtl/prim_mubi_pkg.sv
// Multi-bit boolean encodings for security-relevant enables.
// Only the 4-bit flavour is needed by the boot path.
package prim_mubi_pkg;

  typedef enum logic [3:0] {
    MuBi4True  = 4'h6,
    MuBi4False = 4'h9
  } mubi4_t;

endpackage

// File: rtl/tlul_pkg.sv
// TL-UL channel types used by the instruction-memory host port.
// The idle request keeps d_ready low; a host raises it only while a response is wanted.
package tlul_pkg;
  import prim_mubi_pkg::*;

  typedef enum logic [2:0] {
    PutFullData    = 3'h0,
    PutPartialData = 3'h1,
    Get            = 3'h4
  } tl_a_op_e;

  typedef enum logic [2:0] {
    AccessAck     = 3'h0,
    AccessAckData = 3'h1
  } tl_d_op_e;

  typedef struct packed {
    logic [4:0] rsvd;
    mubi4_t     instr_type;
    logic [6:0] cmd_intg;
    logic [6:0] data_intg;
  } tl_a_user_t;

  localparam tl_a_user_t TL_A_USER_DEFAULT = '{
    rsvd:       5'h0,
    instr_type: MuBi4False,
    cmd_intg:   7'h0,
    data_intg:  7'h0
  };

  typedef struct packed {
    logic [6:0] rsp_intg;
    logic [6:0] data_intg;
  } tl_d_user_t;

  typedef struct packed {
    logic        a_valid;
    tl_a_op_e    a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    tl_a_user_t  a_user;
    logic        d_ready;
  } tl_h2d_t;

  localparam tl_h2d_t TL_H2D_DEFAULT = '{
    a_valid:   1'b0,
    a_opcode:  PutFullData,
    a_param:   3'h0,
    a_size:    2'h0,
    a_source:  8'h0,
    a_address: 32'h0,
    a_mask:    4'h0,
    a_data:    32'h0,
    a_user:    TL_A_USER_DEFAULT,
    d_ready:   1'b0
  };

  typedef struct packed {
    logic        d_valid;
    tl_d_op_e    d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic        d_sink;
    logic [31:0] d_data;
    tl_d_user_t  d_user;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;

endpackage

// File: rtl/boot_seq_tl_host.sv
// Single-outstanding TL-UL host: one full-word Put or Get per request.
// a_* fields depend only on req/we/addr/wdata and local state, never on tl_i.
module boot_seq_tl_host
  import tlul_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        gnt_o,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  output tl_h2d_t     tl_o,
  input  tl_d2h_t     tl_i
);

  logic pending_q, pending_d;

  assign gnt_o    = req_i && !pending_q && tl_i.a_ready;
  // A response only counts once the request has been granted on an earlier edge.
  assign rvalid_o = pending_q && tl_i.d_valid;
  assign rdata_o  = tl_i.d_data;
  assign err_o    = tl_i.d_error;

  always_comb begin
    pending_d = pending_q;
    if (gnt_o) begin
      pending_d = 1'b1;
    end else if (rvalid_o) begin
      pending_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      pending_q <= 1'b0;
    end else begin
      pending_q <= pending_d;
    end
  end

  always_comb begin
    tl_o = TL_H2D_DEFAULT;
    if (req_i && !pending_q) begin
      tl_o.a_valid   = 1'b1;
      tl_o.a_opcode  = we_i ? PutFullData : Get;
      tl_o.a_size    = 2'd2;
      tl_o.a_mask    = 4'hF;
      tl_o.a_address = addr_i;
      tl_o.a_data    = wdata_i;
    end
    tl_o.d_ready = req_i || pending_q;
  end

  logic unused_tl_i;
  assign unused_tl_i = ^{tl_i.d_opcode, tl_i.d_param, tl_i.d_size, tl_i.d_source,
                         tl_i.d_sink, tl_i.d_user};

endmodule

// File: rtl/boot_sequencer.sv
// Loads a program into instruction memory over TL-UL, then releases the core
// (fetch_enable, then en_ifetch). Define BOOT_SEQ_READBACK_EN to verify each word by a Get.
module boot_sequencer
  import boot_seq_pkg::*;
  import tlul_pkg::*;
  import prim_mubi_pkg::*;
#(
  parameter logic [31:0] BaseAddr  = DefaultBaseAddr,
  parameter int unsigned MaxWords  = DefaultMaxWords,
  parameter logic [31:0] EndMarker = DefaultEndMarker
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic                               boot_start_i,
  input  logic                               halt_i,
  input  logic                               word_valid_i,
  input  logic [31:0]                        word_data_i,
  output logic                               word_ready_o,
  output tl_h2d_t                            tl_o,
  input  tl_d2h_t                            tl_i,
  output logic                               fetch_enable_o,
  output mubi4_t                             en_ifetch_o,
  output logic                               boot_done_o,
  output logic                               boot_err_o,
  output logic [$clog2(MaxWords+1)-1:0]      words_o
);

  localparam int unsigned WordsW = $clog2(MaxWords + 1);

  boot_state_e       state_q, state_d;
  logic [WordsW-1:0] words_q, words_d;
  logic [31:0]       word_q, word_d;
  logic              word_ready_q, word_ready_d;
  logic              fetch_enable_q, fetch_enable_d;
  mubi4_t            en_ifetch_q, en_ifetch_d;
  logic              boot_done_q, boot_done_d;
  logic              boot_err_q, boot_err_d;

  logic              host_req, host_we, host_gnt, host_rvalid, host_err;
  logic [31:0]       host_rdata, cur_addr;
  logic              last_word;
  boot_state_e       after_word;
  logic [WordsW-1:0] words_inc;

  assign cur_addr   = word_addr(BaseAddr, 32'(words_q));
  assign words_inc  = words_q + WordsW'(1);
  assign last_word  = (word_q == EndMarker) || (32'(words_inc) == MaxWords);
  assign after_word = last_word ? EN_FETCH : LOAD;
  assign host_req   = state_q inside {REQ, CHK_REQ};
  assign host_we    = (state_q == REQ);

  boot_seq_tl_host u_tl_host (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .req_i    (host_req),
    .we_i     (host_we),
    .addr_i   (cur_addr),
    .wdata_i  (word_q),
    .gnt_o    (host_gnt),
    .rvalid_o (host_rvalid),
    .rdata_o  (host_rdata),
    .err_o    (host_err),
    .tl_o     (tl_o),
    .tl_i     (tl_i)
  );

  always_comb begin
    state_d = state_q;
    words_d = words_q;
    word_d  = word_q;
    case (state_q)
      IDLE: begin
        if (boot_start_i) begin
          state_d = LOAD;
          words_d = '0;
        end
      end
      LOAD: begin
        if (word_valid_i && word_ready_q) begin
          word_d  = word_data_i;
          state_d = REQ;
        end
      end
      REQ: begin
        if (host_gnt) state_d = RSP;
      end
      RSP: begin
        if (host_rvalid) begin
          if (host_err) begin
            state_d = ERROR;
          end else begin
`ifdef BOOT_SEQ_READBACK_EN
            state_d = CHK_REQ;
`else
            words_d = words_inc;
            state_d = after_word;
`endif
          end
        end
      end
`ifdef BOOT_SEQ_READBACK_EN
      CHK_REQ: begin
        if (host_gnt) state_d = CHK_RSP;
      end
      CHK_RSP: begin
        if (host_rvalid) begin
          if (host_err || (host_rdata != word_q)) begin
            state_d = ERROR;
          end else begin
            words_d = words_inc;
            state_d = after_word;
          end
        end
      end
`endif
      EN_FETCH:  state_d = halt_i ? IDLE : EN_IFETCH;
      EN_IFETCH: state_d = halt_i ? IDLE : RUN;
      RUN: begin
        if (halt_i) state_d = IDLE;
      end
      ERROR: begin
        if (boot_start_i) begin
          state_d = LOAD;
          words_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_comb begin
    word_ready_d   = (state_d == LOAD);
    fetch_enable_d = state_d inside {EN_FETCH, EN_IFETCH, RUN};
    en_ifetch_d    = (state_d inside {EN_IFETCH, RUN}) ? MuBi4True : MuBi4False;
    boot_done_d    = (state_d == RUN);
    boot_err_d     = (state_d == ERROR);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q        <= IDLE;
      words_q        <= '0;
      word_q         <= '0;
      word_ready_q   <= 1'b0;
      fetch_enable_q <= 1'b0;
      en_ifetch_q    <= MuBi4False;
      boot_done_q    <= 1'b0;
      boot_err_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      words_q        <= words_d;
      word_q         <= word_d;
      word_ready_q   <= word_ready_d;
      fetch_enable_q <= fetch_enable_d;
      en_ifetch_q    <= en_ifetch_d;
      boot_done_q    <= boot_done_d;
      boot_err_q     <= boot_err_d;
    end
  end

`ifndef BOOT_SEQ_READBACK_EN
  logic unused_rdata;
  assign unused_rdata = ^host_rdata;
`endif

  assign word_ready_o   = word_ready_q;
  assign fetch_enable_o = fetch_enable_q;
  assign en_ifetch_o    = en_ifetch_q;
  assign boot_done_o    = boot_done_q;
  assign boot_err_o     = boot_err_q;
  assign words_o        = words_q;

endmodule
